// File: rtl/ram_pkg.sv
// Shared sizes, word type and boot image for the 128 x 9 program/data RAM.
package ram_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 9;
  localparam int unsigned DEPTH  = 1 << ADDR_W;
  localparam int unsigned INIT_N = 20;

  typedef logic [DATA_W-1:0] word_t;

  // Words loaded into addresses 0x00..0x13 on every reset edge
  localparam word_t BOOT_IMAGE [INIT_N] = '{
    9'h048, 9'h001, 9'h050, 9'h000, 9'h058, 9'h080, 9'h153, 9'h091,
    9'h058, 9'h1FF, 9'h02F, 9'h060, 9'h1FF, 9'h007, 9'h0E1, 9'h1B8,
    9'h0D9, 9'h1BD, 9'h078, 9'h004
  };

endpackage : ram_pkg

// File: rtl/ram_boot_rom.sv
// Combinational boot-image lookup: image word for addresses below INIT_N, zero above.
module ram_boot_rom
  import ram_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output word_t             word
);

  localparam int unsigned IDX_W = $clog2(INIT_N);

  logic [IDX_W-1:0] idx;

  assign idx = addr[IDX_W-1:0];

  // Select the image word, or zero outside the boot region
  always_comb begin
    word = '0;
    if (addr < ADDR_W'(INIT_N)) begin
      word = BOOT_IMAGE[idx];
    end
  end

endmodule : ram_boot_rom

// File: rtl/ram.sv
// 128 x 9 single-port RAM: synchronous write, asynchronous read, reset reloads the boot image.
module ram
  import ram_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              wr_en,
  output logic [DATA_W-1:0] q
);

  word_t mem_q      [DEPTH];
  word_t mem_d      [DEPTH];
  word_t boot_words [DEPTH];

  // One ROM lookup per word so the whole array reloads on a single reset edge
  for (genvar i = 0; i < int'(DEPTH); i++) begin : g_boot
    ram_boot_rom u_boot_rom (
      .addr (ADDR_W'(i)),
      .word (boot_words[i])
    );
  end

  // Next array contents: unchanged except for the addressed word on a write
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[addr] = data;
    end
  end

  // Storage update; reset wins over a simultaneous write
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= boot_words;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Asynchronous read, no bypass of a pending write
  assign q = mem_q[addr];

endmodule : ram

// File: tb/tb_ram.sv
// Self-checking bench for ram: scoreboard of expected read words against a reference memory.
module tb_ram;

  logic       clk;
  logic       rst;
  logic [6:0] addr;
  logic [8:0] data;
  logic       wr_en;
  logic [8:0] q;

  typedef struct {
    logic [6:0] a;
    logic [8:0] e;
  } exp_t;

  exp_t       sb [$];
  exp_t       ex;
  logic [8:0] model [128];
  logic [8:0] boot_tab [20];
  int         n_checks;
  int         n_pass;

  ram dut (
    .clk   (clk),
    .rst   (rst),
    .addr  (addr),
    .data  (data),
    .wr_en (wr_en),
    .q     (q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic load_boot_tab();
    boot_tab = '{9'h048, 9'h001, 9'h050, 9'h000, 9'h058, 9'h080, 9'h153, 9'h091,
                 9'h058, 9'h1FF, 9'h02F, 9'h060, 9'h1FF, 9'h007, 9'h0E1, 9'h1B8,
                 9'h0D9, 9'h1BD, 9'h078, 9'h004};
  endtask

  task automatic model_reset();
    for (int i = 0; i < 128; i++) model[i] = (i < 20) ? boot_tab[i] : 9'h000;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; addr = 7'h00; data = 9'h000;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    sb.push_back('{7'h00, 9'h048});
    sb.push_back('{7'h13, 9'h004});
    for (int k = 0; k < 2; k++) begin
      ex = sb.pop_front();
      addr = ex.a; #1;
      n_checks++;
      if (q !== ex.e) $display("FAIL reset_state addr=%h got=%h exp=%h", ex.a, q, ex.e);
      else n_pass++;
    end
  endtask

  task automatic test_boot_sweep();
    for (int a = 0; a < 20; a++) begin
      @(negedge clk);
      addr = 7'(a);
      sb.push_back('{7'(a), boot_tab[a]});
      #1;
      ex = sb.pop_front();
      n_checks++;
      if (q !== ex.e) $display("FAIL boot_sweep addr=%h got=%h exp=%h", ex.a, q, ex.e);
      else n_pass++;
    end
  endtask

  task automatic test_zero_region();
    logic [6:0] list [4];
    list = '{7'h14, 7'h7F, 7'h15, 7'h40};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      addr = list[k];
      sb.push_back('{list[k], 9'h000});
      #1;
      ex = sb.pop_front();
      n_checks++;
      if (q !== ex.e) $display("FAIL zero_region addr=%h got=%h exp=%h", ex.a, q, ex.e);
      else n_pass++;
    end
  endtask

  task automatic test_neighbour();
    @(negedge clk);
    addr = 7'h05; data = 9'h1AA; wr_en = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
    model[5] = 9'h1AA;
    sb.push_back('{7'h04, 9'h058});
    sb.push_back('{7'h06, 9'h153});
    sb.push_back('{7'h05, 9'h1AA});
    while (sb.size() > 0) begin
      @(negedge clk);
      ex = sb.pop_front();
      addr = ex.a; #1;
      n_checks++;
      if (q !== ex.e) $display("FAIL neighbour addr=%h got=%h exp=%h", ex.a, q, ex.e);
      else n_pass++;
    end
  endtask

  task automatic test_random_writes();
    logic [8:0] wd;
    for (int a = 'h0E; a < 128; a++) begin
      @(negedge clk);
      wd = 9'($urandom);
      addr = 7'(a); data = wd; wr_en = 1'b1;
      sb.push_back('{7'(a), model[a]});
      #1;
      ex = sb.pop_front();
      n_checks++;
      if (q !== ex.e) $display("FAIL rdw_old addr=%h got=%h exp=%h", ex.a, q, ex.e);
      else n_pass++;
      sb.push_back('{7'(a), wd});
      @(posedge clk); #1;
      model[a] = wd;
      ex = sb.pop_front();
      n_checks++;
      if (q !== ex.e) $display("FAIL write_new addr=%h got=%h exp=%h", ex.a, q, ex.e);
      else n_pass++;
    end
    @(negedge clk);
    wr_en = 1'b0;
    sb.push_back('{7'h0D, 9'h007});
    sb.push_back('{7'h0E, model['h0E]});
    sb.push_back('{7'h55, model['h55]});
    sb.push_back('{7'h7F, model['h7F]});
    while (sb.size() > 0) begin
      @(negedge clk);
      ex = sb.pop_front();
      addr = ex.a; #1;
      n_checks++;
      if (q !== ex.e) $display("FAIL readback addr=%h got=%h exp=%h", ex.a, q, ex.e);
      else n_pass++;
    end
  endtask

  task automatic test_reset_priority();
    @(negedge clk);
    addr = 7'h30; data = 9'h123; wr_en = 1'b1;
    sb.push_back('{7'h30, 9'h123});
    @(posedge clk); #1;
    ex = sb.pop_front();
    n_checks++;
    if (q !== ex.e) $display("FAIL pre_reset_write addr=%h got=%h exp=%h", ex.a, q, ex.e);
    else n_pass++;
    @(negedge clk);
    rst = 1'b1; addr = 7'h30; data = 9'h0FF; wr_en = 1'b1;
    sb.push_back('{7'h30, 9'h000});
    @(posedge clk); #1;
    ex = sb.pop_front();
    n_checks++;
    if (q !== ex.e) $display("FAIL reset_priority addr=%h got=%h exp=%h", ex.a, q, ex.e);
    else n_pass++;
    rst = 1'b0; wr_en = 1'b0;
    model_reset();
    sb.push_back('{7'h00, 9'h048});
    sb.push_back('{7'h05, 9'h080});
    sb.push_back('{7'h0F, 9'h1B8});
    sb.push_back('{7'h7F, 9'h000});
    while (sb.size() > 0) begin
      @(negedge clk);
      ex = sb.pop_front();
      addr = ex.a; #1;
      n_checks++;
      if (q !== ex.e) $display("FAIL reset_restore addr=%h got=%h exp=%h", ex.a, q, ex.e);
      else n_pass++;
    end
  endtask

  task automatic test_held_wr_en();
    @(negedge clk);
    addr = 7'h40; data = 9'h155; wr_en = 1'b1;
    sb.push_back('{7'h40, 9'h155});
    @(posedge clk); #1;
    model['h40] = 9'h155;
    ex = sb.pop_front();
    n_checks++;
    if (q !== ex.e) $display("FAIL held_first addr=%h got=%h exp=%h", ex.a, q, ex.e);
    else n_pass++;
    addr = 7'h41; data = 9'h0AA;
    sb.push_back('{7'h41, model['h41]});
    #1;
    ex = sb.pop_front();
    n_checks++;
    if (q !== ex.e) $display("FAIL held_addr_follow addr=%h got=%h exp=%h", ex.a, q, ex.e);
    else n_pass++;
    sb.push_back('{7'h41, 9'h0AA});
    @(posedge clk); #1;
    model['h41] = 9'h0AA;
    ex = sb.pop_front();
    n_checks++;
    if (q !== ex.e) $display("FAIL held_second addr=%h got=%h exp=%h", ex.a, q, ex.e);
    else n_pass++;
    wr_en = 1'b0;
    addr = 7'h40;
    sb.push_back('{7'h40, 9'h155});
    #1;
    ex = sb.pop_front();
    n_checks++;
    if (q !== ex.e) $display("FAIL held_first_kept addr=%h got=%h exp=%h", ex.a, q, ex.e);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    wr_en    = 1'b0;
    addr     = '0;
    data     = '0;
    load_boot_tab();
    test_reset();
    test_boot_sweep();
    test_zero_region();
    test_neighbour();
    test_random_writes();
    test_reset_priority();
    test_held_wr_en();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_ram
